// File: rtl/csa_add_ctrl_pkg.sv
// Shared constants, state encoding and beat-geometry helpers for csa_add_ctrl.
package csa_add_ctrl_pkg;

  // Vector length N per security level.
  localparam int unsigned N_LEV1 = 640;
  localparam int unsigned N_LEV3 = 976;
  localparam int unsigned N_LEV5 = 1344;

  // Beat counter width; covers the largest level even at one lane per beat.
  localparam int unsigned CNT_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Number of beats needed to carry n elements at t lanes per beat.
  function automatic int unsigned beats_for(input int unsigned n, input int unsigned t);
    return (n + t - 1) / t;
  endfunction

  // Valid lanes in the final beat (a full beat when n divides evenly).
  function automatic int unsigned last_lanes_for(input int unsigned n, input int unsigned t);
    return n - (beats_for(n, t) - 1) * t;
  endfunction

  // Only levels 1, 3 and 5 start a job.
  function automatic logic level_valid(input logic [2:0] lev);
    return (lev == 3'd1) || (lev == 3'd3) || (lev == 3'd5);
  endfunction

endpackage

// File: rtl/csa_lane_mask.sv
// Lane-enable vector: all lanes on, except lanes >= last_lanes on the last beat.
module csa_lane_mask #(
  parameter int unsigned T      = 64,
  parameter int unsigned LANE_W = $clog2(T + 1)
) (
  input  logic [LANE_W-1:0] i_last_lanes,
  input  logic              i_is_last,
  output logic [T-1:0]      o_lane_en_c
);

  // Per-lane enable against the valid-lane count of the final beat.
  always_comb begin
    o_lane_en_c = '0;
    for (int k = 0; k < T; k++) begin
      o_lane_en_c[k] = !i_is_last || (LANE_W'(k) < i_last_lanes);
    end
  end

endmodule

// File: rtl/csa_add_ctrl.sv
// Controller for an external combinational lane adder: streams N elements in
// T-lane beats, either as a lane-wise vector add or as a reduction into one
// accumulator. Optional FRODO_MOD_Q_EN masks level-1 results to 15 bits.
module csa_add_ctrl
  import csa_add_ctrl_pkg::*;
#(
  parameter int unsigned T     = 64,
  parameter int unsigned WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [2:0]           i_sec_lev,
  input  logic                 i_start,
  input  logic                 i_op,
  input  logic [WIDTH-1:0]     i_element,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [T*WIDTH-1:0]   i_a,
  input  logic [T*WIDTH-1:0]   i_b,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [T*WIDTH-1:0]   o_out_array,
  output logic [WIDTH-1:0]     o_out_element,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_add_mode,
  output logic [T*WIDTH-1:0]   o_add_a,
  output logic [T*WIDTH-1:0]   o_add_b,
  output logic [T*WIDTH-1:0]   o_add_array,
  output logic [WIDTH-1:0]     o_add_element,
  input  logic [T*WIDTH-1:0]   i_add_array,
  input  logic [WIDTH-1:0]     i_add_element
);

  localparam int unsigned LANE_W = $clog2(T + 1);
  localparam int unsigned VEC_W  = T * WIDTH;

  localparam logic [CNT_W-1:0]  B1 = CNT_W'(beats_for(N_LEV1, T));
  localparam logic [CNT_W-1:0]  B3 = CNT_W'(beats_for(N_LEV3, T));
  localparam logic [CNT_W-1:0]  B5 = CNT_W'(beats_for(N_LEV5, T));
  localparam logic [LANE_W-1:0] L1 = LANE_W'(last_lanes_for(N_LEV1, T));
  localparam logic [LANE_W-1:0] L3 = LANE_W'(last_lanes_for(N_LEV3, T));
  localparam logic [LANE_W-1:0] L5 = LANE_W'(last_lanes_for(N_LEV5, T));

  state_e              state_q, state_d;
  logic                op_q, op_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [LANE_W-1:0]   last_lanes_q, last_lanes_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [VEC_W-1:0]    out_array_q, out_array_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                is_last_c;
  logic [T-1:0]        lane_en_c;
  logic                in_ready_c;
  logic                in_hs_c;
  logic                out_hs_c;
  logic [WIDTH-1:0]    res_mask_c;
  logic [VEC_W-1:0]    add_a_c;
  logic [VEC_W-1:0]    add_b_c;
  logic [VEC_W-1:0]    res_array_c;

  assign is_last_c = (cnt_q == (beats_q - CNT_W'(1)));

  csa_lane_mask #(
    .T      (T),
    .LANE_W (LANE_W)
  ) u_lane_mask (
    .i_last_lanes (last_lanes_q),
    .i_is_last    (is_last_c),
    .o_lane_en_c  (lane_en_c)
  );

`ifdef FRODO_MOD_Q_EN
  localparam logic [WIDTH-1:0] Q_MASK = WIDTH'(32'h7FFF);

  logic lev1_q, lev1_d;
  logic modq_en_c;

  // Level-1 flag latched on an accepted start.
  always_comb begin
    lev1_d = lev1_q;
    if (state_q == ST_IDLE && i_start && level_valid(i_sec_lev)) begin
      lev1_d = (i_sec_lev == 3'd1);
    end
  end

  // Level-1 flag register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lev1_q <= 1'b0;
    else          lev1_q <= lev1_d;
  end

  // In IDLE the seed is masked by the level being started, afterwards by the latched one.
  assign modq_en_c  = (state_q == ST_IDLE) ? (i_sec_lev == 3'd1) : lev1_q;
  assign res_mask_c = modq_en_c ? Q_MASK : '1;
`else
  assign res_mask_c = '1;
`endif

  assign in_ready_c = (state_q == ST_RUN) && (op_q || !out_valid_q || i_out_ready);
  assign in_hs_c    = i_in_valid && in_ready_c;
  assign out_hs_c   = out_valid_q && i_out_ready;

  // Zero disabled lanes on adder operands and on the registered lane results.
  always_comb begin
    add_a_c     = '0;
    add_b_c     = '0;
    res_array_c = '0;
    for (int k = 0; k < T; k++) begin
      if (lane_en_c[k]) begin
        add_a_c[k*WIDTH +: WIDTH]     = i_a[k*WIDTH +: WIDTH];
        add_b_c[k*WIDTH +: WIDTH]     = i_b[k*WIDTH +: WIDTH];
        res_array_c[k*WIDTH +: WIDTH] = i_add_array[k*WIDTH +: WIDTH] & res_mask_c;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    beats_d      = beats_q;
    last_lanes_d = last_lanes_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_array_d  = out_array_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (level_valid(i_sec_lev)) begin
            state_d     = ST_RUN;
            op_d        = i_op;
            cnt_d       = '0;
            acc_d       = i_element & res_mask_c;
            out_valid_d = 1'b0;
            case (i_sec_lev)
              3'd1:    begin beats_d = B1; last_lanes_d = L1; end
              3'd3:    begin beats_d = B3; last_lanes_d = L3; end
              default: begin beats_d = B5; last_lanes_d = L5; end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!op_q) begin
          if (out_hs_c) out_valid_d = 1'b0;
          if (in_hs_c) begin
            out_array_d = res_array_c;
            out_valid_d = 1'b1;
          end
        end else if (in_hs_c) begin
          acc_d = i_add_element & res_mask_c;
          if (is_last_c) out_valid_d = 1'b1;
        end
        if (in_hs_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_last_c) state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (out_hs_c) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset discards any job in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 1'b0;
      beats_q      <= '0;
      last_lanes_q <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_array_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      beats_q      <= beats_d;
      last_lanes_q <= last_lanes_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_array_q  <= out_array_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign o_in_ready    = in_ready_c;
  assign o_out_valid   = out_valid_q;
  assign o_out_array   = out_array_q;
  assign o_out_element = acc_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_add_mode    = op_q;
  assign o_add_a       = add_a_c;
  assign o_add_b       = add_b_c;
  assign o_add_array   = add_a_c;
  assign o_add_element = acc_q;

endmodule

// File: tb/tb_csa_add_ctrl.sv
// Self-checking bench for csa_add_ctrl with a behavioural adder and result model.
module tb_csa_add_ctrl;

  localparam int T = 64;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [2:0]     i_sec_lev;
  logic           i_start;
  logic           i_op;
  logic [W-1:0]   i_element;
  logic           i_in_valid;
  logic           o_in_ready;
  logic [T*W-1:0] i_a;
  logic [T*W-1:0] i_b;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [T*W-1:0] o_out_array;
  logic [W-1:0]   o_out_element;
  logic           o_busy;
  logic           o_done;
  logic           o_err;
  logic           o_add_mode;
  logic [T*W-1:0] o_add_a;
  logic [T*W-1:0] o_add_b;
  logic [T*W-1:0] o_add_array;
  logic [W-1:0]   o_add_element;
  logic [T*W-1:0] add_array;
  logic [W-1:0]   add_element;

  int checks = 0;
  int errors = 0;

  csa_add_ctrl #(.T(T), .WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sec_lev     (i_sec_lev),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_element     (i_element),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_array   (o_out_array),
    .o_out_element (o_out_element),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_add_mode    (o_add_mode),
    .o_add_a       (o_add_a),
    .o_add_b       (o_add_b),
    .o_add_array   (o_add_array),
    .o_add_element (o_add_element),
    .i_add_array   (add_array),
    .i_add_element (add_element)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational adder: lane-wise a+b, and element + sum of array lanes.
  always_comb begin
    logic [W-1:0] s;
    add_array = '0;
    for (int k = 0; k < T; k++) begin
      add_array[k*W +: W] = o_add_a[k*W +: W] + o_add_b[k*W +: W];
    end
    s = o_add_element;
    for (int k = 0; k < T; k++) s = s + o_add_array[k*W +: W];
    add_element = o_add_mode ? s : '0;
  end

  function automatic int level_n(input int lev);
    case (lev)
      1:       return 640;
      3:       return 976;
      default: return 1344;
    endcase
  endfunction

  function automatic int valid_lanes(input int n, input int beat);
    int r;
    r = n - beat * T;
    return (r > T) ? T : r;
  endfunction

  function automatic logic [W-1:0] res_mask(input int lev);
`ifdef FRODO_MOD_Q_EN
    if (lev == 1) return 16'h7FFF;
`endif
    return 16'hFFFF;
  endfunction

  // One complete job: pat 0 random, 1 all ones, 2 lane index, 3 a single 1.
  task automatic run_job(input int lev, input bit op, input logic [W-1:0] seed,
                         input int pat, input int vpct, input int rpct,
                         input int stall_at, output int cyc);
    logic [W-1:0]   am [0:31][0:T-1];
    logic [W-1:0]   bm [0:31][0:T-1];
    logic [T*W-1:0] ev;
    logic [W-1:0]   msk, ee;
    int n, nb, sent, got, stall_left, one_lane;
    bit pend_done, done_seen, stalled, in_hs, out_hs, exp_rdy, exp_ov;
    longint unsigned esum;

    n = level_n(lev);
    nb = (n + T - 1) / T;
    msk = res_mask(lev);
    one_lane = $urandom_range(0, T - 1);
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < T; k++) begin
        case (pat)
          0:       begin am[b][k] = W'($urandom); bm[b][k] = W'($urandom); end
          1:       begin am[b][k] = 16'd1; bm[b][k] = 16'd1; end
          2:       begin am[b][k] = W'(k); bm[b][k] = W'(k); end
          default: begin am[b][k] = (b == 0 && k == one_lane) ? 16'd1 : 16'd0; bm[b][k] = 16'd0; end
        endcase
      end
    end
    esum = longint'(seed);
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < valid_lanes(n, b); k++) esum += longint'(am[b][k]);
    ee = W'(esum) & msk;

    @(negedge clk);
    i_start = 1'b1; i_sec_lev = 3'(lev); i_op = op; i_element = seed;
    i_in_valid = 1'b0; i_out_ready = 1'b0;

    sent = 0; got = 0; cyc = 0; stall_left = 0;
    pend_done = 0; done_seen = 0; stalled = 0;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (pend_done) begin
        i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
        #1;
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse lev=%0d op=%0d: done=%b busy=%b, want done=1 busy=0", lev, op, o_done, o_busy);
        end
        done_seen = 1;
      end else begin
        // Start/level/op/seed changes while busy must all be ignored.
        i_start = ($urandom_range(0, 3) == 0);
        i_sec_lev = 3'($urandom_range(0, 7));
        i_op = 1'($urandom);
        i_element = W'($urandom);
        if (sent < nb) begin
          i_in_valid = ($urandom_range(0, 99) < vpct);
          for (int k = 0; k < T; k++) begin
            i_a[k*W +: W] = am[sent][k];
            i_b[k*W +: W] = bm[sent][k];
          end
        end else begin
          i_in_valid = 1'b1;
          i_a = {T{W'($urandom)}};
          i_b = {T{W'($urandom)}};
        end
        if (!op && !stalled && stall_at >= 0 && got == stall_at && sent > got) begin
          stalled = 1; stall_left = 3;
        end
        if (stall_left > 0) i_out_ready = 1'b0;
        else                i_out_ready = ($urandom_range(0, 99) < rpct);
        #1;
        if (cyc == 1) begin
          checks++;
          if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b want 1", o_busy);
          end
        end
        exp_ov  = op ? (sent == nb) : (sent > got);
        exp_rdy = (sent < nb) && (op || (sent == got) || i_out_ready);
        checks++;
        if (o_out_valid !== exp_ov || o_in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL handshake lev=%0d op=%0d cyc=%0d: out_valid=%b in_ready=%b, want %b %b",
                   lev, op, cyc, o_out_valid, o_in_ready, exp_ov, exp_rdy);
        end
        if (!op && got < nb) begin
          ev = '0;
          for (int k = 0; k < valid_lanes(n, got); k++)
            ev[k*W +: W] = (am[got][k] + bm[got][k]) & msk;
        end
        if (stall_left > 0) begin
          stall_left--;
          checks++;
          if (o_out_array !== ev || o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold beat=%0d: in_ready=%b array_lane0=%h, want 0 %h",
                     got, o_in_ready, o_out_array[W-1:0], ev[W-1:0]);
          end
        end
        in_hs  = i_in_valid && o_in_ready;
        out_hs = o_out_valid && i_out_ready;
        if (in_hs) begin
          checks++;
          if (sent >= nb) begin
            errors++;
            $display("FAIL extra_beat lev=%0d: beat accepted after %0d, want none", lev, nb);
          end else sent++;
        end
        if (out_hs) begin
          checks++;
          if (!op) begin
            if (o_out_array !== ev) begin
              errors++;
              $display("FAIL vadd_beat lev=%0d beat=%0d: lane0=%h lane63=%h, want %h %h",
                       lev, got, o_out_array[W-1:0], o_out_array[T*W-1 -: W], ev[W-1:0], ev[T*W-1 -: W]);
            end
            got++;
            if (got == nb) pend_done = 1;
          end else begin
            if (o_out_element !== ee) begin
              errors++;
              $display("FAIL reduce_elem lev=%0d seed=%h: got %h want %h", lev, seed, o_out_element, ee);
            end
            got++;
            pend_done = 1;
          end
        end
      end
    end
    checks++;
    if (!done_seen || sent != nb) begin
      errors++;
      $display("FAIL job_end lev=%0d op=%0d: done_seen=%0d beats=%0d, want 1 %0d", lev, op, done_seen, sent, nb);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b busy=%b want 0 0", o_done, o_busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_done !== 1'b0 ||
        o_err !== 1'b0 || o_out_array !== '0 || o_out_element !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b ov=%b rdy=%b done=%b err=%b elem=%h arr_nz=%b, want all 0",
               tag, o_busy, o_out_valid, o_in_ready, o_done, o_err, o_out_element, |o_out_array);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("reset_release");
  endtask

  task automatic test_reduce;
    int c;
    run_job(1, 1'b1, 16'd0, 1, 70, 50, -1, c);
    run_job(3, 1'b1, 16'd5, 1, 60, 50, -1, c);
    run_job(5, 1'b1, W'($urandom), 0, 80, 30, -1, c);
  endtask

  task automatic test_vadd;
    int c;
    run_job(3, 1'b0, 16'd0, 2, 100, 100, -1, c);
    run_job(1, 1'b0, 16'd0, 0, 60, 60, -1, c);
    run_job(5, 1'b0, 16'd0, 0, 90, 70, 4, c);
  endtask

  task automatic test_back_to_back;
    int c;
    for (int op = 0; op < 2; op++) begin
      run_job(5, 1'(op), W'($urandom), 0, 100, 100, -1, c);
      checks++;
      if (c != 21 + 2) begin
        errors++;
        $display("FAIL throughput op=%0d: %0d cycles, want %0d", op, c, 23);
      end
    end
  endtask

  task automatic test_random;
    int c, lev;
    for (int j = 0; j < 6; j++) begin
      lev = 2 * $urandom_range(0, 2) + 1;
      run_job(lev, 1'($urandom), W'($urandom), 0, $urandom_range(40, 100), $urandom_range(30, 100), -1, c);
    end
  endtask

  task automatic test_bad_level;
    logic [2:0] bad [0:3];
    bad[0] = 3'd2; bad[1] = 3'd0; bad[2] = 3'd4; bad[3] = 3'd7;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      i_start = 1'b1; i_sec_lev = bad[j]; i_op = 1'($urandom);
      i_in_valid = 1'b0; i_out_ready = 1'b0;
      @(negedge clk);
      i_start = 1'b0;
      #1;
      checks++;
      if (o_err !== 1'b1 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_level lev=%0d: err=%b busy=%b, want 1 0", bad[j], o_err, o_busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_err !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL err_one_cycle lev=%0d: err=%b busy=%b, want 0 0", bad[j], o_err, o_busy);
      end
    end
  endtask

  task automatic test_reset_mid_job;
    int acc, cyc, c;
    @(negedge clk);
    i_start = 1'b1; i_sec_lev = 3'd1; i_op = 1'b0; i_element = '0;
    @(negedge clk);
    i_start = 1'b0; i_in_valid = 1'b1; i_out_ready = 1'b1;
    i_a = {T{16'h1234}}; i_b = {T{16'h0101}};
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 50) begin
      #1;
      if (o_in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (acc != 5) begin
      errors++;
      $display("FAIL reset_setup: accepted %0d beats, want 5", acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_job");
    @(negedge clk);
    i_in_valid = 1'b0; i_out_ready = 1'b0;
    rst_n = 1'b1;
    run_job(1, 1'b0, 16'd0, 0, 80, 80, -1, c);
  endtask

  task automatic test_modq;
    int c;
    run_job(1, 1'b1, 16'h7FFF, 3, 100, 100, -1, c);
    run_job(3, 1'b1, 16'h7FFF, 3, 100, 100, -1, c);
  endtask

  initial begin
    rst_n = 1'b0; i_sec_lev = '0; i_start = 1'b0; i_op = 1'b0; i_element = '0;
    i_in_valid = 1'b0; i_out_ready = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    test_reset;
    test_reduce;
    test_vadd;
    test_back_to_back;
    test_bad_level;
    test_reset_mid_job;
    test_modq;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_add_ctrl.md
CSA_ADD_CTRL -- requirements
Module: csa_add_ctrl

Interface
REQ-001 Parameter T, default 64: lanes per adder beat.
REQ-002 Parameter WIDTH, default 16: bits per lane.
REQ-003 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_sec_lev  in  3  security level; 1->N=640, 3->N=976, 5->N=1344; sampled on accepted start.
REQ-006 i_start  in  1  job request; accepted only in IDLE.
REQ-007 i_op  in  1  0 = lane-wise vector add, 1 = reduction; sampled with i_start.
REQ-008 i_element  in  WIDTH  reduction seed; sampled with i_start.
REQ-009 i_in_valid / o_in_ready  in/out  1  input-beat handshake.
REQ-010 i_a, i_b  in  T*WIDTH  operand beat; lane k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-011 o_out_valid / i_out_ready  out/in  1  result handshake.
REQ-012 o_out_array  out  T*WIDTH  vector-add result beat.
REQ-013 o_out_element  out  WIDTH  reduction result.
REQ-014 o_busy, o_done, o_err  out  1  job active; one-cycle completion pulse; one-cycle bad-level pulse.
REQ-015 o_add_mode, o_add_a, o_add_b, o_add_array, o_add_element  out  1/T*WIDTH/T*WIDTH/T*WIDTH/WIDTH  drive to the combinational adder.
REQ-016 i_add_array, i_add_element  in  T*WIDTH/WIDTH  adder results, same cycle.

Function
REQ-017 States SHALL be IDLE, RUN, FLUSH; IDLE->RUN on i_start with valid level; RUN->FLUSH after last beat accepted; FLUSH->IDLE on final output handshake.
REQ-018 Beats per job SHALL be B = ceil(N/T); last beat carries L = N-(B-1)*T valid lanes (T=64: B=10/16/21, L=64/16/0->64).
REQ-019 Lanes >= L on the last beat SHALL be forced to zero on o_add_a, o_add_b, o_add_array.
REQ-020 op 0: o_add_mode=0, o_add_a/b = masked i_a/i_b; i_add_array registered into o_out_array on each input handshake, o_out_valid set next cycle.
REQ-021 op 0: o_in_ready = RUN && (!o_out_valid || i_out_ready); one beat per cycle sustained; results in input order, latency 1 cycle.
REQ-022 op 1: o_add_mode=1, o_add_array = masked i_a, o_add_element = accumulator; accumulator <= i_add_element per accepted beat; o_in_ready = RUN.
REQ-023 op 1: in FLUSH o_out_element = accumulator, o_out_valid held high until i_out_ready.
REQ-024 Accumulation and lane sums SHALL wrap modulo 2^WIDTH.
REQ-025 o_done SHALL pulse in the cycle after the final output handshake (op 0: last beat out; op 1: element out).
REQ-026 i_start with i_sec_lev not in {1,3,5}: no job, stay IDLE, o_err pulses next cycle.
REQ-027 i_start outside IDLE SHALL be ignored; o_busy = (state != IDLE).
REQ-028 Beat counter SHALL not wrap: no input accepted in FLUSH.

Reset
REQ-029 On i_rst_n low, immediately: state IDLE, counter 0, accumulator 0, o_out_valid/o_done/o_err/o_busy/o_in_ready 0, output registers 0; a job in flight is discarded.

Configuration
REQ-030 With FRODO_MOD_Q_EN defined, when level 1 is latched, every registered result (o_out_array lanes, accumulator) SHALL be masked to 15 bits (q=2^15); levels 3/5 unchanged.
REQ-031 Without FRODO_MOD_Q_EN, all levels keep full WIDTH bits.

Structure
REQ-032 Shared package holds the level->N table, beat count/last-lane constants, and state encoding.
REQ-033 One sub-module, csa_lane_mask, generates the T-bit lane-enable vector from L and the last-beat flag.

Verification
REQ-034 Level 1, op 1, seed 0, all lanes 1 -> 10 beats accepted, o_out_element=640, o_done 1 cycle after handshake.
REQ-035 Level 3, op 1, seed 5, all lanes 1 -> 16 beats, o_out_element=981 (lanes 16..63 of beat 16 ignored).
REQ-036 Level 3, op 0, lane k of a and b = k -> beats 1..15 lane k = 2k; beat 16 lanes 0..15 = 2k, lanes 16..63 = 0.
REQ-037 op 0, i_out_ready low 3 cycles mid-job -> o_out_array stable, o_in_ready low, no beat lost or duplicated.
REQ-038 i_sec_lev=2 with i_start -> o_err pulse, o_busy stays 0; reset asserted at beat 5 -> outputs 0 at once, next job correct.
REQ-039 FRODO_MOD_Q_EN defined, level 1, op 1, seed 0x7FFF, lanes all 0 except one lane 1 -> o_out_element=0x0000.
